// File: rtl/prco_regs_bank.sv
// rtl/prco_regs_bank.sv - PRCO register bank: 2R/1W, byte lanes, bypass, busy scoreboard
module prco_regs_bank #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_sela,
  output logic [DATA_W-1:0]   q_data,
  input  logic [ADDR_W-1:0]   i_selb,
  output logic [DATA_W-1:0]   q_datb,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_seld,
  input  logic [DATA_W-1:0]   i_datd,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic                i_lock,
  input  logic [ADDR_W-1:0]   i_lsel,
  output logic                q_busya,
  output logic                q_busyb
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int NLANE = DATA_W / 8;
  localparam bit R0_Z  = (ZERO_R0 != 0);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0][DATA_W-1:0] regs_nxt;
  logic [NREG-1:0]             busy;
  logic [NREG-1:0]             busy_nxt;

  logic                        wr_ok;
  logic                        lock_ok;
  logic [DATA_W-1:0]           rd_a;
  logic [DATA_W-1:0]           rd_b;
  logic                        bs_a;
  logic                        bs_b;

  // A hard-wired R0 swallows writes and locks aimed at it
  always_comb begin
    wr_ok   = i_we && !(R0_Z && (i_seld == '0));
    lock_ok = i_lock && !(R0_Z && (i_lsel == '0));
  end

  // Post-edge register and busy state: lane merge, then clear-on-write, then lock (lock wins)
  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    if (wr_ok) begin
      for (int k = 0; k < NLANE; k++) begin
        if (i_be[k]) begin
          regs_nxt[i_seld][8*k +: 8] = i_datd[8*k +: 8];
        end
      end
    end
    if (i_we) begin
      busy_nxt[i_seld] = 1'b0;
    end
    if (lock_ok) begin
      busy_nxt[i_lsel] = 1'b1;
    end
  end

  // Read ports look at the post-edge state, which gives write-to-read bypass for free
  always_comb begin
    rd_a = regs_nxt[i_sela];
    rd_b = regs_nxt[i_selb];
    bs_a = busy_nxt[i_sela];
    bs_b = busy_nxt[i_selb];
    if (R0_Z && (i_sela == '0)) begin
      rd_a = '0;
      bs_a = 1'b0;
    end
    if (R0_Z && (i_selb == '0)) begin
      rd_b = '0;
      bs_b = 1'b0;
    end
  end

  // State and registered outputs; reset beats the clock enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      regs    <= '0;
      busy    <= '0;
      q_data  <= '0;
      q_datb  <= '0;
      q_busya <= 1'b0;
      q_busyb <= 1'b0;
    end else if (i_en) begin
      regs    <= regs_nxt;
      busy    <= busy_nxt;
      q_data  <= rd_a;
      q_datb  <= rd_b;
      q_busya <= bs_a;
      q_busyb <= bs_b;
    end
  end

endmodule

// File: tb/tb_prco_regs_bank.sv
// tb/tb_prco_regs_bank.sv - scoreboard bench for prco_regs_bank with and without hard-wired R0
module tb_prco_regs_bank;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_en = 1'b0;
  logic [2:0]  i_sela = '0;
  logic [2:0]  i_selb = '0;
  logic        i_we = 1'b0;
  logic [2:0]  i_seld = '0;
  logic [15:0] i_datd = '0;
  logic [1:0]  i_be = '0;
  logic        i_lock = 1'b0;
  logic [2:0]  i_lsel = '0;

  logic [15:0] q_data0, q_datb0, q_data1, q_datb1;
  logic        q_busya0, q_busyb0, q_busya1, q_busyb1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] da0, db0, da1, db1;
    logic        ba0, bb0, ba1, bb1;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] m_reg [2][8];
  logic        m_busy [2][8];
  logic [15:0] m_qa [2];
  logic [15:0] m_qb [2];
  logic        m_ba [2];
  logic        m_bb [2];

  prco_regs_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en),
    .i_sela(i_sela), .q_data(q_data0), .i_selb(i_selb), .q_datb(q_datb0),
    .i_we(i_we), .i_seld(i_seld), .i_datd(i_datd), .i_be(i_be),
    .i_lock(i_lock), .i_lsel(i_lsel), .q_busya(q_busya0), .q_busyb(q_busyb0)
  );

  prco_regs_bank #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en),
    .i_sela(i_sela), .q_data(q_data1), .i_selb(i_selb), .q_datb(q_datb1),
    .i_we(i_we), .i_seld(i_seld), .i_datd(i_datd), .i_be(i_be),
    .i_lock(i_lock), .i_lsel(i_lsel), .q_busya(q_busya1), .q_busyb(q_busyb1)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one edge for both R0 variants
  task automatic model_edge();
    for (int v = 0; v < 2; v++) begin
      if (i_reset) begin
        for (int r = 0; r < 8; r++) begin
          m_reg[v][r] = '0;
          m_busy[v][r] = 1'b0;
        end
        m_qa[v] = '0; m_qb[v] = '0; m_ba[v] = 1'b0; m_bb[v] = 1'b0;
      end else if (i_en) begin
        if (i_we) begin
          if (!(v == 1 && i_seld == 3'd0)) begin
            if (i_be[0]) m_reg[v][i_seld][7:0] = i_datd[7:0];
            if (i_be[1]) m_reg[v][i_seld][15:8] = i_datd[15:8];
          end
          m_busy[v][i_seld] = 1'b0;
        end
        if (i_lock && !(v == 1 && i_lsel == 3'd0)) m_busy[v][i_lsel] = 1'b1;
        m_qa[v] = (v == 1 && i_sela == 3'd0) ? 16'h0 : m_reg[v][i_sela];
        m_qb[v] = (v == 1 && i_selb == 3'd0) ? 16'h0 : m_reg[v][i_selb];
        m_ba[v] = (v == 1 && i_sela == 3'd0) ? 1'b0 : m_busy[v][i_sela];
        m_bb[v] = (v == 1 && i_selb == 3'd0) ? 1'b0 : m_busy[v][i_selb];
      end
    end
  endtask

  // Push the expectation, clock one edge, pop and compare against both instances
  task automatic step(input string tag);
    exp_t e;
    model_edge();
    e.da0 = m_qa[0]; e.db0 = m_qb[0]; e.ba0 = m_ba[0]; e.bb0 = m_bb[0];
    e.da1 = m_qa[1]; e.db1 = m_qb[1]; e.ba1 = m_ba[1]; e.bb1 = m_bb[1];
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".da0"}, q_data0, e.da0);
      check({tag, ".db0"}, q_datb0, e.db0);
      check({tag, ".ba0"}, {15'd0, q_busya0}, {15'd0, e.ba0});
      check({tag, ".bb0"}, {15'd0, q_busyb0}, {15'd0, e.bb0});
      check({tag, ".da1"}, q_data1, e.da1);
      check({tag, ".db1"}, q_datb1, e.db1);
      check({tag, ".ba1"}, {15'd0, q_busya1}, {15'd0, e.ba1});
      check({tag, ".bb1"}, {15'd0, q_busyb1}, {15'd0, e.bb1});
    end
  endtask

  task automatic idle();
    i_reset = 1'b0; i_en = 1'b1; i_we = 1'b0; i_lock = 1'b0; i_be = 2'b00;
  endtask

  initial begin
    for (int v = 0; v < 2; v++) begin
      for (int r = 0; r < 8; r++) begin
        m_reg[v][r] = 'x;
        m_busy[v][r] = 'x;
      end
      m_qa[v] = 'x; m_qb[v] = 'x; m_ba[v] = 'x; m_bb[v] = 'x;
    end

    // 1: reset with enable low, then sweep all registers on both ports
    i_reset = 1'b1; i_en = 1'b0; i_we = 1'b1; i_seld = 3'd2; i_datd = 16'hDEAD; i_be = 2'b11;
    i_lock = 1'b1; i_lsel = 3'd2;
    step("reset");
    check("reset_q_data", q_data0, 16'h0000);
    idle();
    for (int r = 0; r < 8; r++) begin
      i_sela = 3'(r); i_selb = 3'(7 - r);
      step($sformatf("rst_read_r%0d", r));
      check($sformatf("rst_zero_r%0d", r), q_data0 | q_datb0, 16'h0000);
    end

    // 2: full write then read one cycle later
    i_we = 1'b1; i_seld = 3'd1; i_datd = 16'hF0F0; i_be = 2'b11; i_sela = 3'd0; i_selb = 3'd0;
    step("wr_r1");
    idle(); i_sela = 3'd1; i_selb = 3'd1;
    step("rd_r1");
    check("r1_value", q_data0, 16'hF0F0);
    check("r1_portb", q_datb1, 16'hF0F0);

    // 3: partial lane write with same-cycle bypass
    i_we = 1'b1; i_seld = 3'd2; i_datd = 16'h1234; i_be = 2'b11;
    step("wr_r2");
    i_we = 1'b1; i_seld = 3'd2; i_datd = 16'hABCD; i_be = 2'b01; i_sela = 3'd2; i_selb = 3'd1;
    step("bypass_r2");
    check("bypass_lane", q_data0, 16'h12CD);
    idle(); i_sela = 3'd1; i_selb = 3'd2;
    step("rd_r2");
    check("r2_after", q_datb0, 16'h12CD);
    i_we = 1'b1; i_seld = 3'd2; i_datd = 16'hFFFF; i_be = 2'b00; i_sela = 3'd2;
    step("be_zero");
    check("be_zero_keep", q_data0, 16'h12CD);

    // 4: lock, write-clears, lock beats write on the same register
    idle(); i_lock = 1'b1; i_lsel = 3'd3; i_sela = 3'd3; i_selb = 3'd3;
    step("lock_r3");
    check("busy_set", {15'd0, q_busya0}, 16'd1);
    idle(); i_we = 1'b1; i_seld = 3'd3; i_datd = 16'h0303; i_be = 2'b11;
    step("write_r3");
    check("busy_clr", {15'd0, q_busya0}, 16'd0);
    idle(); i_we = 1'b1; i_seld = 3'd3; i_datd = 16'h3333; i_be = 2'b11; i_lock = 1'b1; i_lsel = 3'd3;
    step("lock_write_r3");
    check("lock_wins", {15'd0, q_busya0}, 16'd1);
    idle(); i_we = 1'b1; i_seld = 3'd3; i_be = 2'b10; i_datd = 16'h4400; i_lock = 1'b1; i_lsel = 3'd6;
    i_sela = 3'd3; i_selb = 3'd6;
    step("lock_write_diff");
    check("diff_lock", {15'd0, q_busyb0}, 16'd1);

    // 5: hard-wired R0 ignores writes and locks
    idle(); i_we = 1'b1; i_seld = 3'd0; i_datd = 16'hFFFF; i_be = 2'b11; i_lock = 1'b1; i_lsel = 3'd0;
    i_sela = 3'd0; i_selb = 3'd0;
    step("r0_wr_lock");
    check("r0_zero_data", q_data1, 16'h0000);
    check("r0_zero_busy", {15'd0, q_busya1}, 16'd0);
    check("r0_normal_data", q_data0, 16'hFFFF);

    // 6: clock enable low holds everything; reset eats a same-cycle write
    idle(); i_sela = 3'd4; i_selb = 3'd1;
    step("rd_r4");
    i_en = 1'b0; i_we = 1'b1; i_seld = 3'd4; i_datd = 16'h5555; i_be = 2'b11; i_lock = 1'b1; i_lsel = 3'd4;
    i_sela = 3'd2; i_selb = 3'd2;
    step("hold");
    check("hold_q_data", q_data0, 16'h0000);
    idle(); i_sela = 3'd4; i_selb = 3'd4;
    step("r4_unchanged");
    check("r4_value", q_data0, 16'h0000);
    i_reset = 1'b1; i_we = 1'b1; i_seld = 3'd5; i_datd = 16'h7777; i_be = 2'b11;
    step("reset_write");
    idle(); i_sela = 3'd5; i_selb = 3'd3;
    step("r5_after_reset");
    check("r5_zero", q_data0, 16'h0000);
    check("r3_zero", q_datb0, 16'h0000);

    // Mixed traffic against the scoreboard
    for (int n = 0; n < 200; n++) begin
      i_reset = ($urandom_range(0, 49) == 0);
      i_en    = ($urandom_range(0, 7) != 0);
      i_we    = $urandom_range(0, 1);
      i_lock  = ($urandom_range(0, 2) == 0);
      i_seld  = 3'($urandom_range(0, 7));
      i_lsel  = 3'($urandom_range(0, 7));
      i_sela  = 3'($urandom_range(0, 7));
      i_selb  = 3'($urandom_range(0, 7));
      i_datd  = 16'($urandom);
      i_be    = 2'($urandom_range(0, 3));
      step($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
